// File: rtl/mem_access_unit.sv
// LEGv8 load/store unit: splits 64-bit register loads/stores into one or two
// 32-bit word accesses on the data memory and returns the assembled result.
module mem_access_unit #(
  parameter int ADDR_W = 8,
  parameter int WORD_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic              req_dword,
  input  logic              req_signed,
  input  logic [63:0]       req_addr,
  input  logic [63:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [63:0]       resp_rdata,
  output logic              resp_err,
  output logic              mem_read_flag,
  output logic              mem_write_flag,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  input  logic [WORD_W-1:0] mem_rdata
);

  typedef enum logic [2:0] {IDLE, LO, HI, WAIT, DONE} state_t;

  state_t state, next_state;

  logic [ADDR_W-1:0] addr_q;
  logic [63:0]       wdata_q;
  logic              write_q, dword_q, signed_q;
  logic [WORD_W-1:0] lo_q, lo_d;

  logic              accept, req_err;
  logic              req_ready_d, resp_valid_d, resp_err_d;
  logic [63:0]       resp_rdata_d;
  logic              rd_d, wr_d;
  logic [ADDR_W-1:0] addr_d;
  logic [WORD_W-1:0] wdata_d;

  assign accept  = req_valid && req_ready;
  assign req_err = (req_dword ? (req_addr[2:0] != 3'b000) : (req_addr[1:0] != 2'b00))
                 || (req_addr[63:ADDR_W+2] != '0);

  // Outputs are registered, so each branch computes what the outputs must
  // show during the state being entered.
  always_comb begin
    next_state   = state;
    lo_d         = lo_q;
    resp_valid_d = resp_valid;
    resp_err_d   = resp_err;
    resp_rdata_d = resp_rdata;
    rd_d         = 1'b0;
    wr_d         = 1'b0;
    addr_d       = mem_addr;
    wdata_d      = mem_wdata;
    case (state)
      IDLE: begin
        if (accept) begin
          if (req_err) begin
            next_state   = DONE;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            resp_rdata_d = '0;
          end else begin
            next_state = LO;
            addr_d     = req_addr[ADDR_W+1:2];
            wr_d       = req_write;
            rd_d       = !req_write;
            if (req_write) wdata_d = req_wdata[WORD_W-1:0];
          end
        end
      end
      LO: begin
        if (dword_q) begin
          next_state = HI;
          addr_d     = addr_q + ADDR_W'(1);
          wr_d       = write_q;
          rd_d       = !write_q;
          if (write_q) wdata_d = wdata_q[2*WORD_W-1:WORD_W];
        end else if (write_q) begin
          next_state   = DONE;
          resp_valid_d = 1'b1;
          resp_rdata_d = '0;
        end else begin
          next_state = WAIT;
        end
      end
      HI: begin
        if (write_q) begin
          next_state   = DONE;
          resp_valid_d = 1'b1;
          resp_rdata_d = '0;
        end else begin
          next_state = WAIT;
          lo_d       = mem_rdata;
        end
      end
      WAIT: begin
        next_state   = DONE;
        resp_valid_d = 1'b1;
        if (dword_q)
          resp_rdata_d = {mem_rdata, lo_q};
        else
          resp_rdata_d = {{(64-WORD_W){signed_q & mem_rdata[WORD_W-1]}}, mem_rdata};
      end
      DONE: begin
        if (resp_ready) begin
          next_state   = IDLE;
          resp_valid_d = 1'b0;
          resp_err_d   = 1'b0;
          resp_rdata_d = '0;
        end
      end
      default: next_state = IDLE;
    endcase
    req_ready_d = (next_state == IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      req_ready      <= 1'b1;
      resp_valid     <= 1'b0;
      resp_err       <= 1'b0;
      resp_rdata     <= '0;
      mem_read_flag  <= 1'b0;
      mem_write_flag <= 1'b0;
      mem_addr       <= '0;
      mem_wdata      <= '0;
      lo_q           <= '0;
      addr_q         <= '0;
      wdata_q        <= '0;
      write_q        <= 1'b0;
      dword_q        <= 1'b0;
      signed_q       <= 1'b0;
    end else begin
      state          <= next_state;
      req_ready      <= req_ready_d;
      resp_valid     <= resp_valid_d;
      resp_err       <= resp_err_d;
      resp_rdata     <= resp_rdata_d;
      mem_read_flag  <= rd_d;
      mem_write_flag <= wr_d;
      mem_addr       <= addr_d;
      mem_wdata      <= wdata_d;
      lo_q           <= lo_d;
      if (accept) begin
        addr_q   <= req_addr[ADDR_W+1:2];
        wdata_q  <= req_wdata;
        write_q  <= req_write;
        dword_q  <= req_dword;
        signed_q <= req_signed;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: a 256-word memory with 1-cycle read
// latency, directed scenarios, then random requests checked against a word-array model.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_write, req_dword, req_signed;
  logic [63:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready, resp_err;
  logic [63:0] resp_rdata;
  logic        mem_read_flag, mem_write_flag;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;

  logic [31:0] mem [256];
  logic [31:0] ref_mem [256];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.ADDR_W(8), .WORD_W(32)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_dword(req_dword), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_read_flag(mem_read_flag), .mem_write_flag(mem_write_flag),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always @(posedge clk) begin
    if (mem_write_flag) mem[mem_addr] <= mem_wdata;
    if (mem_read_flag) mem_rdata <= mem[mem_addr];
  end

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check_output({tag, " req_ready"}, 64'(req_ready), 64'd1);
    check_output({tag, " resp_valid"}, 64'(resp_valid), 64'd0);
    check_output({tag, " resp_err"}, 64'(resp_err), 64'd0);
    check_output({tag, " resp_rdata"}, resp_rdata, 64'd0);
    check_output({tag, " strobes"}, {62'd0, mem_read_flag, mem_write_flag}, 64'd0);
    check_output({tag, " mem_addr"}, 64'(mem_addr), 64'd0);
    check_output({tag, " mem_wdata"}, 64'(mem_wdata), 64'd0);
  endtask

  // One complete transaction; starts and ends just after a falling edge.
  task automatic apply_stimulus(input logic w, input logic d, input logic s,
                                input logic [63:0] a, input logic [63:0] wd,
                                input int stall);
    bit          err;
    int          idx, exp_lat, exp_strobes, lat, nstrobes;
    logic [63:0] exp_rdata;
    err = (d ? (a % 8 != 0) : (a % 4 != 0)) || (a >= 64'd1024);
    idx = int'((a / 4) % 256);
    if (err) exp_lat = 1;
    else if (w) exp_lat = d ? 3 : 2;
    else exp_lat = d ? 4 : 3;
    exp_strobes = err ? 0 : (d ? 2 : 1);
    if (err || w) exp_rdata = 64'd0;
    else if (d) exp_rdata = {ref_mem[idx+1], ref_mem[idx]};
    else if (s) exp_rdata = 64'($signed(ref_mem[idx]));
    else exp_rdata = {32'd0, ref_mem[idx]};

    resp_ready = (stall == 0);
    req_valid  = 1'b1;
    req_write  = w;
    req_dword  = d;
    req_signed = s;
    req_addr   = a;
    req_wdata  = wd;
    check_output("req_ready_before_accept", 64'(req_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 0;
    nstrobes = 0;
    for (int c = 1; c <= 8; c++) begin
      check_output("read_write_exclusive", 64'(mem_read_flag & mem_write_flag), 64'd0);
      if (mem_read_flag || mem_write_flag) begin
        nstrobes++;
        check_output("strobe_in_window", 64'(c <= exp_strobes), 64'd1);
        check_output("strobe_addr", 64'(mem_addr), 64'((idx + c - 1) % 256));
        check_output("strobe_kind", {62'd0, mem_read_flag, mem_write_flag}, {62'd0, !w, w});
        if (w) check_output("strobe_wdata", 64'(mem_wdata), (c == 1) ? 64'(wd[31:0]) : 64'(wd[63:32]));
      end
      if (resp_valid) begin
        lat = c;
        break;
      end
      @(negedge clk);
    end
    check_output("resp_latency", 64'(lat), 64'(exp_lat));
    check_output("strobe_count", 64'(nstrobes), 64'(exp_strobes));
    check_output("resp_rdata", resp_rdata, exp_rdata);
    check_output("resp_err", 64'(resp_err), 64'(err));

    for (int i = 0; i < stall; i++) begin
      check_output("stall_resp_valid", 64'(resp_valid), 64'd1);
      check_output("stall_resp_rdata", resp_rdata, exp_rdata);
      check_output("stall_req_ready", 64'(req_ready), 64'd0);
      @(negedge clk);
    end
    if (stall > 0) begin
      check_output("stall_final_valid", 64'(resp_valid), 64'd1);
      resp_ready = 1'b1;
      @(negedge clk);
    end else begin
      @(negedge clk);
    end
    check_output("post_handshake_valid", 64'(resp_valid), 64'd0);
    check_output("post_handshake_ready", 64'(req_ready), 64'd1);

    if (!err && w) begin
      ref_mem[idx] = wd[31:0];
      if (d) ref_mem[idx+1] = wd[63:32];
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic        w, d, s;
    logic [63:0] a;
    int          idx, r;
    for (int i = 0; i < 256; i++) begin
      mem[i]     = 32'(i);
      ref_mem[i] = 32'(i);
    end
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_dword = 1'b0;
    req_signed = 1'b0; req_addr = '0; req_wdata = '0; resp_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_state("reset");
    reset = 1'b0;
    @(negedge clk);

    $display("[TB] directed scenarios");
    apply_stimulus(1'b0, 1'b1, 1'b0, 64'h10, 64'd0, 0);
    apply_stimulus(1'b1, 1'b1, 1'b0, 64'h20, 64'hDEADBEEFCAFEF00D, 0);
    check_output("mem8_after_store", 64'(mem[8]), 64'hCAFEF00D);
    check_output("mem9_after_store", 64'(mem[9]), 64'hDEADBEEF);
    apply_stimulus(1'b0, 1'b1, 1'b0, 64'h20, 64'd0, 0);
    apply_stimulus(1'b1, 1'b0, 1'b0, 64'h24, 64'h80000000, 0);
    apply_stimulus(1'b0, 1'b0, 1'b1, 64'h24, 64'd0, 0);
    apply_stimulus(1'b0, 1'b0, 1'b0, 64'h24, 64'd0, 0);
    apply_stimulus(1'b0, 1'b1, 1'b0, 64'h14, 64'd0, 0);
    apply_stimulus(1'b0, 1'b0, 1'b0, 64'h400, 64'd0, 0);
    apply_stimulus(1'b0, 1'b1, 1'b0, 64'h18, 64'd0, 3);

    // Reset lands on the edge that would have entered the high-word access.
    req_valid = 1'b1; req_write = 1'b1; req_dword = 1'b1; req_signed = 1'b0;
    req_addr = 64'h30; req_wdata = 64'h1111111122222222;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check_output("rst_lo_write_strobe", 64'(mem_write_flag), 64'd1);
    check_output("rst_lo_addr", 64'(mem_addr), 64'd12);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_reset_state("mid_op_reset");
    reset = 1'b0;
    @(negedge clk);
    check_reset_state("after_reset_idle");
    check_output("mem12_kept", 64'(mem[12]), 64'h22222222);
    check_output("mem13_untouched", 64'(mem[13]), 64'd13);
    ref_mem[12] = 32'h22222222;
    apply_stimulus(1'b0, 1'b1, 1'b0, 64'h30, 64'd0, 0);

    $display("[TB] random requests");
    for (int n = 0; n < 40; n++) begin
      w   = 1'($urandom_range(0, 1));
      d   = 1'($urandom_range(0, 1));
      s   = 1'($urandom_range(0, 1));
      idx = $urandom_range(0, 255);
      if (d) idx = idx - (idx % 2);
      a = 64'(idx) * 4;
      r = $urandom_range(0, 9);
      if (r == 0) a = a + 64'(d ? $urandom_range(1, 7) : $urandom_range(1, 3));
      else if (r == 1) a = a + 64'h400 * 64'($urandom_range(1, 1000));
      else if (r == 2) a = a | 64'h8000000000000000;
      apply_stimulus(w, d, s, a, {$urandom(), $urandom()}, $urandom_range(0, 2));
    end

    for (int i = 0; i < 256; i++)
      if (mem[i] !== ref_mem[i])
        check_output($sformatf("final_mem[%0d]", i), 64'(mem[i]), 64'(ref_mem[i]));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
